// File: rtl/fetch_redirect_sequencer.sv
// Fetch PC owner: sequential advance, branch/jump redirect, trap steering,
// and a fixed-length pipeline flush window after every redirect.
module fetch_redirect_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exec_valid,
    input  logic        exec_jump_pc,
    input  logic [31:0] exec_pc_out,
    input  logic        exec_exception_valid,
    input  logic [5:0]  exec_exception_num,
    input  logic [31:0] trap_vector,
    input  logic        fetch_ready,
    output logic [31:0] fetch_pc,
    output logic        fetch_valid,
    output logic        flush,
    output logic        exception_valid_out,
    output logic [5:0]  exception_num_out,
    output logic [31:0] exception_tval_out,
    output logic [15:0] redirect_count
);

    localparam logic [1:0] START = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam logic [3:0] DRAIN_LOAD = 4'(FLUSH_CYCLES - 1);

    logic [1:0] state;
    logic [3:0] drain;

    logic take_exc;
    logic take_misalign;
    logic take_jump;
    logic take_trap;
    logic take_redirect;

    always_comb begin
        take_exc      = exec_valid && exec_exception_valid;
        take_misalign = exec_valid && exec_jump_pc && (exec_pc_out[1:0] != 2'b00);
        take_jump     = exec_valid && exec_jump_pc;
        take_trap     = take_exc || take_misalign;
        take_redirect = take_trap || take_jump;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= START;
            drain               <= 4'd0;
            fetch_pc            <= RESET_PC;
            fetch_valid         <= 1'b0;
            flush               <= 1'b0;
            exception_valid_out <= 1'b0;
            exception_num_out   <= 6'd0;
            exception_tval_out  <= 32'd0;
            redirect_count      <= 16'd0;
        end else begin
            exception_valid_out <= 1'b0;
            unique case (state)
                START: begin
                    fetch_valid <= 1'b1;
                    state       <= RUN;
                end
                RUN: begin
                    if (take_redirect) begin
                        if (take_trap) begin
                            fetch_pc            <= trap_vector;
                            exception_valid_out <= 1'b1;
                            exception_num_out   <= take_exc ? exec_exception_num : 6'd0;
                            exception_tval_out  <= exec_pc_out;
                        end else begin
                            fetch_pc <= exec_pc_out;
                        end
                        if (redirect_count != 16'hFFFF)
                            redirect_count <= redirect_count + 16'd1;
                        flush       <= 1'b1;
                        fetch_valid <= 1'b0;
                        drain       <= DRAIN_LOAD;
                        state       <= FLUSH;
                    end else if (fetch_valid && fetch_ready) begin
                        fetch_pc <= fetch_pc + 32'd4;
                    end
                end
                FLUSH: begin
                    // Results arriving here are stale and deliberately dropped.
                    if (drain == 4'd0) begin
                        flush       <= 1'b0;
                        fetch_valid <= 1'b1;
                        state       <= RUN;
                    end else begin
                        drain <= drain - 4'd1;
                    end
                end
                default: begin
                    state       <= START;
                    fetch_valid <= 1'b0;
                    flush       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_redirect_sequencer.sv
// Directed bench for fetch_redirect_sequencer: advance, redirect, trap,
// stale-result drop, PC wrap and asynchronous reset during flush.
module tb_fetch_redirect_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        exec_valid;
    logic        exec_jump_pc;
    logic [31:0] exec_pc_out;
    logic        exec_exception_valid;
    logic [5:0]  exec_exception_num;
    logic [31:0] trap_vector;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        flush;
    logic        exception_valid_out;
    logic [5:0]  exception_num_out;
    logic [31:0] exception_tval_out;
    logic [15:0] redirect_count;

    int total = 0;
    int bad   = 0;

    fetch_redirect_sequencer dut (
        .clk                  (clk),
        .reset                (reset),
        .exec_valid           (exec_valid),
        .exec_jump_pc         (exec_jump_pc),
        .exec_pc_out          (exec_pc_out),
        .exec_exception_valid (exec_exception_valid),
        .exec_exception_num   (exec_exception_num),
        .trap_vector          (trap_vector),
        .fetch_ready          (fetch_ready),
        .fetch_pc             (fetch_pc),
        .fetch_valid          (fetch_valid),
        .flush                (flush),
        .exception_valid_out  (exception_valid_out),
        .exception_num_out    (exception_num_out),
        .exception_tval_out   (exception_tval_out),
        .redirect_count       (redirect_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exec();
        exec_valid           = 1'b0;
        exec_jump_pc         = 1'b0;
        exec_exception_valid = 1'b0;
    endtask

    initial begin
        reset                = 1'b1;
        exec_valid           = 1'b0;
        exec_jump_pc         = 1'b0;
        exec_pc_out          = 32'd0;
        exec_exception_valid = 1'b0;
        exec_exception_num   = 6'd0;
        trap_vector          = 32'h8000_0000;
        fetch_ready          = 1'b0;
        step();
        step();
        chk("rst_pc", fetch_pc, 32'h0);
        chk("rst_valid", 32'(fetch_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_exc", 32'(exception_valid_out), 32'd0);
        chk("rst_cnt", 32'(redirect_count), 32'd0);

        // 1: sequential fetch
        reset       = 1'b0;
        fetch_ready = 1'b1;
        step();
        chk("t1_valid", 32'(fetch_valid), 32'd1);
        chk("t1_pc0", fetch_pc, 32'h0);
        step();
        chk("t1_pc4", fetch_pc, 32'h4);
        step();
        chk("t1_pc8", fetch_pc, 32'h8);
        step();
        chk("t1_pcC", fetch_pc, 32'hC);

        // 2: taken jump, redirect beats concurrent fetch_ready
        exec_valid   = 1'b1;
        exec_jump_pc = 1'b1;
        exec_pc_out  = 32'h100;
        step();
        clear_exec();
        fetch_ready = 1'b0;
        chk("t2_flush1", 32'(flush), 32'd1);
        chk("t2_valid1", 32'(fetch_valid), 32'd0);
        chk("t2_exc", 32'(exception_valid_out), 32'd0);
        chk("t2_cnt", 32'(redirect_count), 32'd1);
        step();
        chk("t2_flush2", 32'(flush), 32'd1);
        chk("t2_valid2", 32'(fetch_valid), 32'd0);
        step();
        chk("t2_flush3", 32'(flush), 32'd0);
        chk("t2_valid3", 32'(fetch_valid), 32'd1);
        chk("t2_pc", fetch_pc, 32'h100);

        // 4: exception together with jump
        exec_valid           = 1'b1;
        exec_jump_pc         = 1'b1;
        exec_exception_valid = 1'b1;
        exec_exception_num   = 6'd13;
        exec_pc_out          = 32'h200;
        step();
        clear_exec();
        chk("t4_exc", 32'(exception_valid_out), 32'd1);
        chk("t4_num", 32'(exception_num_out), 32'd13);
        chk("t4_tval", exception_tval_out, 32'h200);
        chk("t4_cnt", 32'(redirect_count), 32'd2);
        step();
        chk("t4_exc_pulse", 32'(exception_valid_out), 32'd0);
        chk("t4_num_hold", 32'(exception_num_out), 32'd13);
        step();
        chk("t4_valid", 32'(fetch_valid), 32'd1);
        chk("t4_pc", fetch_pc, 32'h8000_0000);

        // 3: misaligned target, then 5: stale result during FLUSH
        trap_vector  = 32'h0000_1000;
        exec_valid   = 1'b1;
        exec_jump_pc = 1'b1;
        exec_pc_out  = 32'h102;
        step();
        chk("t3_exc", 32'(exception_valid_out), 32'd1);
        chk("t3_num", 32'(exception_num_out), 32'd0);
        chk("t3_tval", exception_tval_out, 32'h102);
        chk("t3_cnt", 32'(redirect_count), 32'd3);
        exec_pc_out = 32'h300;
        fetch_ready = 1'b1;
        step();
        clear_exec();
        fetch_ready = 1'b0;
        chk("t5_flush", 32'(flush), 32'd1);
        chk("t5_exc0", 32'(exception_valid_out), 32'd0);
        chk("t3_tval_hold", exception_tval_out, 32'h102);
        chk("t5_cnt", 32'(redirect_count), 32'd3);
        step();
        chk("t3_valid", 32'(fetch_valid), 32'd1);
        chk("t3_pc", fetch_pc, 32'h1000);
        step();
        chk("t5_noflush", 32'(flush), 32'd0);
        chk("t5_pc_stable", fetch_pc, 32'h1000);

        // 5: not-taken result in RUN does not block the +4
        exec_valid  = 1'b1;
        exec_pc_out = 32'h400;
        fetch_ready = 1'b1;
        step();
        clear_exec();
        fetch_ready = 1'b0;
        chk("t5_nt_pc", fetch_pc, 32'h1004);
        chk("t5_nt_flush", 32'(flush), 32'd0);
        chk("t5_nt_cnt", 32'(redirect_count), 32'd3);

        // 6: wrap at top of address space
        exec_valid   = 1'b1;
        exec_jump_pc = 1'b1;
        exec_pc_out  = 32'hFFFF_FFFC;
        step();
        clear_exec();
        step();
        step();
        chk("t6_pc_top", fetch_pc, 32'hFFFF_FFFC);
        chk("t6_cnt", 32'(redirect_count), 32'd4);
        fetch_ready = 1'b1;
        step();
        fetch_ready = 1'b0;
        chk("t6_wrap", fetch_pc, 32'h0);

        // 6: asynchronous reset in the middle of FLUSH
        exec_valid   = 1'b1;
        exec_jump_pc = 1'b1;
        exec_pc_out  = 32'h500;
        step();
        clear_exec();
        chk("t6_in_flush", 32'(flush), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_flush", 32'(flush), 32'd0);
        chk("t6_rst_pc", fetch_pc, 32'h0);
        chk("t6_rst_valid", 32'(fetch_valid), 32'd0);
        chk("t6_rst_cnt", 32'(redirect_count), 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("t6_restart", 32'(fetch_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
